// File: rtl/laser310_ps2_keyboard.sv
// PS/2 set-2 keyboard receiver and LASER310 8x6 key matrix; KEY_DATA is the active-low column read.
// Define KEYBOARD_EXT_KEYS_EN to add cursor/ESC/backspace keys that map onto CTRL+key combinations.
`timescale 1ns/1ps
module laser310_ps2_keyboard #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       CLK10MHZ,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic [7:0] KEY_ADDR,
    output logic [5:0] KEY_DATA,
    output logic       RX_VALID,
    output logic [7:0] RX_CODE,
    output logic       FRAME_ERR
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam int IDX_CTRL  = 1 * 6 + 2;
    localparam int IDX_SHIFT = 2 * 6 + 2;
    localparam int IDX_M     = 4 * 6 + 5;
    localparam int IDX_SPC   = 4 * 6 + 4;
    localparam int IDX_COMMA = 4 * 6 + 3;
    localparam int IDX_DOT   = 4 * 6 + 1;
    localparam int IDX_MINUS = 5 * 6 + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // {valid, row*6+col} for a matrix position
    function automatic logic [6:0] at(input int r, input int c);
        at = {1'b1, 6'(r * 6 + c)};
    endfunction

    logic [1:0]       clk_sync_q, dat_sync_q;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             flt_clk_q, flt_clk_d;
    logic             strobe;
    logic             bit_in;

    rx_state_t        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       rx_code_q, rx_code_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic [47:0]      pressed_q, pressed_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic [6:0]       key_map;
    logic             lsh_hit, rsh_hit;
`ifdef KEYBOARD_EXT_KEYS_EN
    logic [5:0]       ex_q, ex_d;
    logic [5:0]       ex_hit;
`endif
    logic [47:0]      view;
    logic [5:0]       col_acc;

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        flt_cnt_d = flt_cnt_q;
        flt_clk_d = flt_clk_q;
        if (clk_sync_q[1] == flt_clk_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            flt_clk_d = clk_sync_q[1];
            flt_cnt_d = '0;
        end else begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
        end
    end

    assign strobe = flt_clk_q & ~flt_clk_d;
    assign bit_in = dat_sync_q[1];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        tmo_d       = '0;
        rx_code_d   = rx_code_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (state_q != ST_IDLE) begin
            tmo_d = strobe ? '0 : tmo_q + TMO_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    if (!bit_in) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (strobe) begin
                    par_ok_d = ^{shift_q, bit_in};
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (strobe) begin
                    state_d = ST_IDLE;
                    if (bit_in && par_ok_q) begin
                        rx_code_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Keyboard went silent mid-frame: drop the partial byte
        if (state_q != ST_IDLE && !strobe && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end
    end

    always_comb begin
        key_map = '0;
        lsh_hit = 1'b0;
        rsh_hit = 1'b0;
`ifdef KEYBOARD_EXT_KEYS_EN
        ex_hit  = '0;
`endif
        if (!ext_q) begin
            case (rx_code_q)
                8'h2D: key_map = at(0, 5);
                8'h15: key_map = at(0, 4);
                8'h24: key_map = at(0, 3);
                8'h1D: key_map = at(0, 1);
                8'h2C: key_map = at(0, 0);
                8'h2B: key_map = at(1, 5);
                8'h1C: key_map = at(1, 4);
                8'h23: key_map = at(1, 3);
                8'h14: key_map = at(1, 2);
                8'h1B: key_map = at(1, 1);
                8'h34: key_map = at(1, 0);
                8'h2A: key_map = at(2, 5);
                8'h1A: key_map = at(2, 4);
                8'h21: key_map = at(2, 3);
                8'h22: key_map = at(2, 1);
                8'h32: key_map = at(2, 0);
                8'h25: key_map = at(3, 5);
                8'h16: key_map = at(3, 4);
                8'h26: key_map = at(3, 3);
                8'h1E: key_map = at(3, 1);
                8'h2E: key_map = at(3, 0);
                8'h3A: key_map = at(4, 5);
                8'h29: key_map = at(4, 4);
                8'h41: key_map = at(4, 3);
                8'h49: key_map = at(4, 1);
                8'h31: key_map = at(4, 0);
                8'h3D: key_map = at(5, 5);
                8'h45: key_map = at(5, 4);
                8'h3E: key_map = at(5, 3);
                8'h4E: key_map = at(5, 2);
                8'h46: key_map = at(5, 1);
                8'h36: key_map = at(5, 0);
                8'h3C: key_map = at(6, 5);
                8'h4D: key_map = at(6, 4);
                8'h43: key_map = at(6, 3);
                8'h5A: key_map = at(6, 2);
                8'h44: key_map = at(6, 1);
                8'h35: key_map = at(6, 0);
                8'h3B: key_map = at(7, 5);
                8'h4C: key_map = at(7, 4);
                8'h42: key_map = at(7, 3);
                8'h52: key_map = at(7, 2);
                8'h4B: key_map = at(7, 1);
                8'h33: key_map = at(7, 0);
                8'h12: lsh_hit = 1'b1;
                8'h59: rsh_hit = 1'b1;
`ifdef KEYBOARD_EXT_KEYS_EN
                8'h76: ex_hit[4] = 1'b1;
                8'h66: ex_hit[5] = 1'b1;
`endif
                default: ;
            endcase
        end else begin
            case (rx_code_q)
                8'h14: key_map = at(1, 2);
`ifdef KEYBOARD_EXT_KEYS_EN
                8'h6B: ex_hit[0] = 1'b1;
                8'h74: ex_hit[1] = 1'b1;
                8'h75: ex_hit[2] = 1'b1;
                8'h72: ex_hit[3] = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Prefix bytes only set flags; any other byte consumes and clears them
    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        pressed_d = pressed_q;
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
`ifdef KEYBOARD_EXT_KEYS_EN
        ex_d      = ex_q;
`endif
        if (rx_valid_q) begin
            if (rx_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                if (key_map[6]) pressed_d[key_map[5:0]] = ~brk_q;
                if (lsh_hit) lshift_d = ~brk_q;
                if (rsh_hit) rshift_d = ~brk_q;
`ifdef KEYBOARD_EXT_KEYS_EN
                ex_d = brk_q ? (ex_q & ~ex_hit) : (ex_q | ex_hit);
`endif
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    always_comb begin
        view            = pressed_q;
        view[IDX_SHIFT] = lshift_q | rshift_q;
`ifdef KEYBOARD_EXT_KEYS_EN
        if (|ex_q)               view[IDX_CTRL]  = 1'b1;
        if (ex_q[0] | ex_q[5])   view[IDX_M]     = 1'b1;
        if (ex_q[1])             view[IDX_COMMA] = 1'b1;
        if (ex_q[2])             view[IDX_DOT]   = 1'b1;
        if (ex_q[3])             view[IDX_SPC]   = 1'b1;
        if (ex_q[4])             view[IDX_MINUS] = 1'b1;
`endif
        col_acc = '0;
        for (int r = 0; r < 8; r++) begin
            if (!KEY_ADDR[r]) col_acc = col_acc | view[r*6 +: 6];
        end
    end

    assign KEY_DATA  = ~col_acc;
    assign RX_VALID  = rx_valid_q;
    assign RX_CODE   = rx_code_q;
    assign FRAME_ERR = frame_err_q;

    always_ff @(negedge CLK10MHZ) begin
        if (RESET) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            flt_cnt_q   <= '0;
            flt_clk_q   <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            rx_code_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            pressed_q   <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
`ifdef KEYBOARD_EXT_KEYS_EN
            ex_q        <= '0;
`endif
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q  <= {dat_sync_q[0], PS2_DATA};
            flt_cnt_q   <= flt_cnt_d;
            flt_clk_q   <= flt_clk_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            rx_code_q   <= rx_code_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            pressed_q   <= pressed_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
`ifdef KEYBOARD_EXT_KEYS_EN
            ex_q        <= ex_d;
`endif
        end
    end

endmodule

// File: tb/tb_laser310_ps2_keyboard.sv
// Self-checking bench for laser310_ps2_keyboard: directed scenarios plus random key traffic vs a key-table model.
`timescale 1ns/1ps
module tb_laser310_ps2_keyboard;

    localparam int FLT  = 8;
    localparam int TMO  = 10000;
    localparam int HALF = 12;

    logic       clk = 1'b0;
    logic       RESET, PS2_CLK, PS2_DATA;
    logic [7:0] KEY_ADDR;
    logic [5:0] KEY_DATA;
    logic       RX_VALID, FRAME_ERR;
    logic [7:0] RX_CODE;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    // Reference model: logical keys with one or two matrix positions
    int lut[int];
    int lr[$], lc[$], lr2[$], lc2[$];
    int cand_ext[$], cand_code[$];
    bit down[64];

    laser310_ps2_keyboard #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK10MHZ(clk), .RESET(RESET), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .KEY_ADDR(KEY_ADDR), .KEY_DATA(KEY_DATA), .RX_VALID(RX_VALID),
        .RX_CODE(RX_CODE), .FRAME_ERR(FRAME_ERR)
    );

    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (RX_VALID) valid_cnt <= valid_cnt + 1;
        if (FRAME_ERR) err_cnt <= err_cnt + 1;
    end

    initial begin
        #9000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DATA = b;
        tick(HALF);
        PS2_CLK = 1'b0;
        tick(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(~bad_stop);
        PS2_DATA = 1'b1;
        tick(HALF + FLT + 8);
    endtask

    task automatic send_key(input int ext, input int code, input bit brk);
        if (ext != 0) send_frame(8'hE0, 0, 0);
        if (brk) send_frame(8'hF0, 0, 0);
        send_frame(8'(code), 0, 0);
    endtask

    task automatic add_key(input int ext, input int code, input int r, input int c,
                           input int r2, input int c2);
        lr.push_back(r); lc.push_back(c); lr2.push_back(r2); lc2.push_back(c2);
        lut[ext * 256 + code] = lr.size() - 1;
        cand_ext.push_back(ext); cand_code.push_back(code);
    endtask

    task automatic add_unmapped(input int ext, input int code);
        cand_ext.push_back(ext); cand_code.push_back(code);
    endtask

    task automatic model_init();
        add_key(0,'h2D,0,5,-1,-1); add_key(0,'h15,0,4,-1,-1); add_key(0,'h24,0,3,-1,-1);
        add_key(0,'h1D,0,1,-1,-1); add_key(0,'h2C,0,0,-1,-1);
        add_key(0,'h2B,1,5,-1,-1); add_key(0,'h1C,1,4,-1,-1); add_key(0,'h23,1,3,-1,-1);
        add_key(0,'h14,1,2,-1,-1); add_key(0,'h1B,1,1,-1,-1); add_key(0,'h34,1,0,-1,-1);
        lut[256 + 'h14] = lut['h14]; add_unmapped(1, 'h14);
        add_key(0,'h2A,2,5,-1,-1); add_key(0,'h1A,2,4,-1,-1); add_key(0,'h21,2,3,-1,-1);
        add_key(0,'h12,2,2,-1,-1); add_key(0,'h59,2,2,-1,-1);
        add_key(0,'h22,2,1,-1,-1); add_key(0,'h32,2,0,-1,-1);
        add_key(0,'h25,3,5,-1,-1); add_key(0,'h16,3,4,-1,-1); add_key(0,'h26,3,3,-1,-1);
        add_key(0,'h1E,3,1,-1,-1); add_key(0,'h2E,3,0,-1,-1);
        add_key(0,'h3A,4,5,-1,-1); add_key(0,'h29,4,4,-1,-1); add_key(0,'h41,4,3,-1,-1);
        add_key(0,'h49,4,1,-1,-1); add_key(0,'h31,4,0,-1,-1);
        add_key(0,'h3D,5,5,-1,-1); add_key(0,'h45,5,4,-1,-1); add_key(0,'h3E,5,3,-1,-1);
        add_key(0,'h4E,5,2,-1,-1); add_key(0,'h46,5,1,-1,-1); add_key(0,'h36,5,0,-1,-1);
        add_key(0,'h3C,6,5,-1,-1); add_key(0,'h4D,6,4,-1,-1); add_key(0,'h43,6,3,-1,-1);
        add_key(0,'h5A,6,2,-1,-1); add_key(0,'h44,6,1,-1,-1); add_key(0,'h35,6,0,-1,-1);
        add_key(0,'h3B,7,5,-1,-1); add_key(0,'h4C,7,4,-1,-1); add_key(0,'h42,7,3,-1,-1);
        add_key(0,'h52,7,2,-1,-1); add_key(0,'h4B,7,1,-1,-1); add_key(0,'h33,7,0,-1,-1);
`ifdef KEYBOARD_EXT_KEYS_EN
        add_key(1,'h6B,4,5,1,2); add_key(1,'h74,4,3,1,2); add_key(1,'h75,4,1,1,2);
        add_key(1,'h72,4,4,1,2); add_key(0,'h76,5,2,1,2); add_key(0,'h66,4,5,1,2);
`else
        add_unmapped(1,'h6B); add_unmapped(1,'h74); add_unmapped(1,'h75);
        add_unmapped(1,'h72); add_unmapped(0,'h76); add_unmapped(0,'h66);
`endif
        add_unmapped(0,'h05); add_unmapped(0,'h0D); add_unmapped(1,'h5A); add_unmapped(1,'h1F);
    endtask

    function automatic void model_apply(input int ext, input int code, input bit brk);
        if (lut.exists(ext * 256 + code)) down[lut[ext * 256 + code]] = !brk;
    endfunction

    function automatic logic [5:0] model_kd(input logic [7:0] addr);
        logic [5:0] acc = '0;
        for (int k = 0; k < lr.size(); k++) begin
            if (down[k]) begin
                if (!addr[lr[k]]) acc[lc[k]] = 1'b1;
                if (lr2[k] >= 0 && !addr[lr2[k]]) acc[lc2[k]] = 1'b1;
            end
        end
        return ~acc;
    endfunction

    task automatic test_reset();
        RESET = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; KEY_ADDR = 8'h00;
        tick(4);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL reset_keydata got=%h exp=3f", KEY_DATA); end
        tests++; if (RX_VALID !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", RX_VALID); end
        tests++; if (RX_CODE !== 8'h00) begin fails++; $display("FAIL reset_rx_code got=%h exp=00", RX_CODE); end
        tests++; if (FRAME_ERR !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", FRAME_ERR); end
        RESET = 1'b0;
        tick(3);
    endtask

    task automatic test_single_key();
        int v0 = valid_cnt;
        send_frame(8'h1C, 0, 0);
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL single_valid_pulses got=%0d exp=1", valid_cnt - v0); end
        tests++; if (RX_CODE !== 8'h1C) begin fails++; $display("FAIL single_rx_code got=%h exp=1c", RX_CODE); end
        KEY_ADDR = 8'hFD; tick(1);
        tests++; if (KEY_DATA !== 6'b101111) begin fails++; $display("FAIL single_press got=%b exp=101111", KEY_DATA); end
        send_key(0, 'h1C, 1);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL single_release got=%b exp=111111", KEY_DATA); end
        tests++; if (RX_CODE !== 8'h1C) begin fails++; $display("FAIL single_rx_code_held got=%h exp=1c", RX_CODE); end
    endtask

    task automatic test_two_keys();
        send_key(0, 'h15, 0);
        send_key(0, 'h5A, 0);
        KEY_ADDR = 8'hFE; tick(1);
        tests++; if (KEY_DATA !== 6'b101111) begin fails++; $display("FAIL two_row0 got=%b exp=101111", KEY_DATA); end
        KEY_ADDR = 8'hBF; tick(1);
        tests++; if (KEY_DATA !== 6'b111011) begin fails++; $display("FAIL two_row6 got=%b exp=111011", KEY_DATA); end
        KEY_ADDR = 8'h00; tick(1);
        tests++; if (KEY_DATA !== 6'b101011) begin fails++; $display("FAIL two_all got=%b exp=101011", KEY_DATA); end
        KEY_ADDR = 8'hFF; tick(1);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL two_none got=%b exp=111111", KEY_DATA); end
        // repeated make then a single break must release Q
        send_key(0, 'h15, 0);
        send_key(0, 'h15, 1);
        send_key(0, 'h5A, 1);
        send_key(0, 'h1C, 1);
        KEY_ADDR = 8'h00; tick(1);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL two_released got=%b exp=111111", KEY_DATA); end
    endtask

    task automatic test_shift();
        send_key(0, 'h12, 0);
        send_key(0, 'h59, 0);
        send_key(0, 'h12, 1);
        KEY_ADDR = 8'hFB; tick(1);
        tests++; if (KEY_DATA !== 6'b111011) begin fails++; $display("FAIL shift_right_held got=%b exp=111011", KEY_DATA); end
        send_key(0, 'h59, 1);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL shift_released got=%b exp=111111", KEY_DATA); end
    endtask

    task automatic test_frame_errors();
        int v0, e0;
        KEY_ADDR = 8'hFD;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1, 0);
        tests++; if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            fails++; $display("FAIL bad_parity err=%0d valid=%0d exp err=1 valid=0", err_cnt - e0, valid_cnt - v0); end
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL bad_parity_matrix got=%b exp=111111", KEY_DATA); end
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 0, 1);
        tests++; if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            fails++; $display("FAIL bad_stop err=%0d valid=%0d exp err=1 valid=0", err_cnt - e0, valid_cnt - v0); end
        v0 = valid_cnt; e0 = err_cnt;
        PS2_CLK = 1'b0; tick(FLT - 1); PS2_CLK = 1'b1; tick(FLT + 10);
        tests++; if (err_cnt - e0 !== 0 || valid_cnt - v0 !== 0) begin
            fails++; $display("FAIL glitch err=%0d valid=%0d exp 0 0", err_cnt - e0, valid_cnt - v0); end
        e0 = err_cnt;
        ps2_bit(1'b1); tick(FLT + 8);
        tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL bad_start err=%0d exp=1", err_cnt - e0); end
        // a dropped byte must not disturb a pending break prefix
        send_key(0, 'h1C, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 1, 0);
        tests++; if (KEY_DATA !== 6'b101111) begin fails++; $display("FAIL err_keeps_state got=%b exp=101111", KEY_DATA); end
        send_frame(8'h1C, 0, 0);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL err_then_break got=%b exp=111111", KEY_DATA); end
    endtask

    task automatic test_timeout();
        int first = -1, pulses = 0, e0;
        e0 = err_cnt;
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
        PS2_DATA = 1'b1; tick(HALF);
        PS2_CLK = 1'b0;
        for (int k = 1; k <= TMO + FLT + 40; k++) begin
            tick(1);
            if (k == HALF) PS2_CLK = 1'b1;
            if (FRAME_ERR === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        tests++; if (first < TMO + FLT || first > TMO + FLT + 4) begin
            fails++; $display("FAIL timeout_latency got=%0d exp=%0d..%0d", first, TMO + FLT, TMO + FLT + 4); end
        tests++; if (pulses !== 1 || err_cnt - e0 !== 1) begin
            fails++; $display("FAIL timeout_pulse got=%0d exp=1", pulses); end
        send_frame(8'h1C, 0, 0);
        KEY_ADDR = 8'hFD; tick(1);
        tests++; if (KEY_DATA !== 6'b101111 || RX_CODE !== 8'h1C) begin
            fails++; $display("FAIL after_timeout got=%b/%h exp=101111/1c", KEY_DATA, RX_CODE); end
        send_key(0, 'h1C, 1);
    endtask

    task automatic test_reset_midframe();
        send_key(0, 'h1C, 0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        RESET = 1'b1; tick(3);
        KEY_ADDR = 8'h00; tick(1);
        tests++; if (KEY_DATA !== 6'h3F || RX_VALID !== 1'b0 || RX_CODE !== 8'h00 || FRAME_ERR !== 1'b0) begin
            fails++; $display("FAIL midframe_reset got=%b/%b/%h/%b exp=111111/0/00/0", KEY_DATA, RX_VALID, RX_CODE, FRAME_ERR); end
        RESET = 1'b0; tick(3);
        send_key(0, 'h29, 0);
        KEY_ADDR = 8'hEF; tick(1);
        tests++; if (KEY_DATA !== 6'b101111 || RX_CODE !== 8'h29) begin
            fails++; $display("FAIL post_reset_spc got=%b/%h exp=101111/29", KEY_DATA, RX_CODE); end
        send_key(0, 'h29, 1);
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        send_frame(8'h2D, 0, 0); send_frame(8'h24, 0, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h2D, 0, 0);
        KEY_ADDR = 8'hFE; tick(1);
        tests++; if (valid_cnt - v0 !== 4) begin fails++; $display("FAIL b2b_valid got=%0d exp=4", valid_cnt - v0); end
        tests++; if (KEY_DATA !== 6'b110111) begin fails++; $display("FAIL b2b_matrix got=%b exp=110111", KEY_DATA); end
        send_key(0, 'h24, 1);
    endtask

    task automatic test_ext_keys();
        logic [5:0] exp_kd;
        send_key(1, 'h6B, 0);
        KEY_ADDR = 8'hEC; tick(1);
`ifdef KEYBOARD_EXT_KEYS_EN
        exp_kd = 6'b011011;
`else
        exp_kd = 6'h3F;
`endif
        tests++; if (KEY_DATA !== exp_kd) begin fails++; $display("FAIL ext_left got=%b exp=%b", KEY_DATA, exp_kd); end
        send_key(1, 'h6B, 1);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL ext_left_release got=%b exp=111111", KEY_DATA); end
        send_key(1, 'h14, 0);
        KEY_ADDR = 8'hFD; tick(1);
        tests++; if (KEY_DATA !== 6'b111011) begin fails++; $display("FAIL ext_rctrl got=%b exp=111011", KEY_DATA); end
        send_key(1, 'h14, 1);
        tests++; if (KEY_DATA !== 6'h3F) begin fails++; $display("FAIL ext_rctrl_release got=%b exp=111111", KEY_DATA); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int idx, ext, code, v0, e0, nbytes;
            bit brk;
            idx = $urandom_range(0, cand_code.size() - 1);
            ext = cand_ext[idx]; code = cand_code[idx];
            brk = 1'($urandom_range(0, 1));
            v0 = valid_cnt; e0 = err_cnt;
            send_key(ext, code, brk);
            model_apply(ext, code, brk);
            nbytes = 1 + ext + int'(brk);
            tests++; if (valid_cnt - v0 !== nbytes || err_cnt - e0 !== 0 || RX_CODE !== 8'(code)) begin
                fails++; $display("FAIL rand_rx code=%h got valid=%0d err=%0d rx=%h exp valid=%0d err=0", code,
                                  valid_cnt - v0, err_cnt - e0, RX_CODE, nbytes); end
            for (int a = 0; a < 3; a++) begin
                logic [7:0] addr;
                addr = (a == 0) ? ~(8'h01 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
                KEY_ADDR = addr; tick(1);
                tests++; if (KEY_DATA !== model_kd(addr)) begin
                    fails++; $display("FAIL rand_matrix addr=%h got=%b exp=%b", addr, KEY_DATA, model_kd(addr)); end
            end
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_single_key();
        test_two_keys();
        test_shift();
        test_frame_errors();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_ext_keys();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
